mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IF_BYTES, default 64, bytes per instruction-block fetch (16 instructions).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port rdy  input  1  global enable; when 0, all state frozen.
REQ-005 SHALL have port mem_din  input  8  RAM read byte, valid the cycle after its address is driven.
REQ-006 SHALL have port mem_dout  output  8  RAM write byte.
REQ-007 SHALL have port mem_a  output  32  RAM byte address.
REQ-008 SHALL have port mem_wr  output  1  1 = write mem_dout to mem_a this cycle.
REQ-009 SHALL have port io_buffer_full  input  1  UART buffer full; stalls IO writes.
REQ-010 SHALL have port if_en  input  1  fetch request, held until if_done.
REQ-011 SHALL have port if_pc  input  32  block base address, low 6 bits zero.
REQ-012 SHALL have port if_done  output  1  one-cycle pulse, if_data valid.
REQ-013 SHALL have port if_data  output  512  block, byte k at bits [8k+7:8k].
REQ-014 SHALL have port lsb_en  input  1  load/store request, held until lsb_done.
REQ-015 SHALL have port lsb_wr  input  1  1 = store, 0 = load.
REQ-016 SHALL have port lsb_addr  input  32  byte address.
REQ-017 SHALL have port lsb_len  input  3  access size in bytes: 1, 2 or 4.
REQ-018 SHALL have port lsb_w_data  input  32  store data, byte 0 = bits [7:0].
REQ-019 SHALL have port lsb_done  output  1  one-cycle completion pulse.
REQ-020 SHALL have port lsb_r_data  output  32  load data, zero-extended.
REQ-021 SHALL have port rob_clear  input  1  pipeline flush.

Function
REQ-022 SHALL implement states IDLE, IF_READ, LS_READ, LS_WRITE, plus a 7-bit byte counter.
REQ-023 In IDLE, with if_done and lsb_done both low, SHALL accept lsb_en in preference to if_en; SHALL ignore requests in any cycle in which either done is high.
REQ-024 IF_READ/LS_READ: drive base+k on mem_a in cycle k and capture mem_din into byte k-1 in cycle k; total N+1 cycles from acceptance; done pulses on the following cycle, with the returned data stable from then until the next accepted request.
REQ-025 LS_WRITE: in cycle k, drive mem_wr=1, mem_a=base+k, mem_dout=byte k; lsb_done pulses the cycle after the last byte.
REQ-026 SHALL stall (mem_wr=0, counter held) a write cycle when io_buffer_full=1 and lsb_addr[17:16]==2'b11.
REQ-027 SHALL hold mem_wr=0 in all non-write cycles.
REQ-028 When rob_clear=1 in IF_READ or LS_READ, SHALL return to IDLE on the next edge with no done pulse.
REQ-029 SHALL let LS_WRITE run to completion regardless of rob_clear.
REQ-030 When rob_clear=1 in IDLE, SHALL accept no request that cycle.
REQ-031 SHALL compute addresses as 32-bit base+counter, wrapping modulo 2^32.
REQ-032 When rdy=0, SHALL hold all state and outputs except mem_wr, which SHALL be forced to 0.

Reset
REQ-033 When rst=0, SHALL immediately enter IDLE, clear the counter, and drive mem_wr=0, mem_a=0, mem_dout=0, if_done=0, lsb_done=0, if_data=0, lsb_r_data=0.
REQ-034 Reset asserted mid-transfer SHALL abort that transfer with no done pulse.

Structure
REQ-035 SHALL place the state encoding, IF_BYTES, and the IO address-range constant in the shared macros package.
REQ-036 SHALL be a single module with no submodules.

Verification
REQ-037 Fetch: if_en=1, if_pc=0x100, RAM[0x100+k]=k -> if_done pulses on cycle 66, if_data byte k = k.
REQ-038 Simultaneous requests: lsb_en (load, 4 bytes @0x20 = 0xDEADBEEF) and if_en both 1 -> load served first, lsb_r_data=0x0000_0000 then 0xDEADBEEF at lsb_done; fetch starts after.
REQ-039 Store of 2 bytes 0xABCD @0x30 -> mem_wr high 2 cycles, writing 0xCD@0x30 and 0xAB@0x31; lsb_done 1 cycle later.
REQ-040 IO store 1 byte @0x30000 with io_buffer_full=1 for 3 cycles -> no write until the flag drops, then exactly one write.
REQ-041 rob_clear at fetch byte 10 -> no if_done, IDLE next cycle; a store in flight when rob_clear asserts completes.
REQ-042 rst=0 mid-load -> all outputs 0 asynchronously, no lsb_done; a new request after release is served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: state encoding, fetch block
// size and the IO address segment that is subject to UART back-pressure.
package mem_ctrl_pkg;

  localparam int unsigned IF_BYTES_DEF = 64;
  localparam int unsigned CNT_W        = 7;
  localparam logic [1:0]  IO_SEG       = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: serves load/store requests ahead of instruction
// block fetches, one RAM byte per cycle, with flush and IO back-pressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned IF_BYTES = IF_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  if_en,
  input  logic [31:0]           if_pc,
  output logic                  if_done,
  output logic [IF_BYTES*8-1:0] if_data,
  input  logic                  lsb_en,
  input  logic                  lsb_wr,
  input  logic [31:0]           lsb_addr,
  input  logic [2:0]            lsb_len,
  input  logic [31:0]           lsb_w_data,
  output logic                  lsb_done,
  output logic [31:0]           lsb_r_data,
  input  logic                  rob_clear
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [31:0]           base_q, base_d;
  logic [2:0]            len_q, len_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           ld_buf_q, ld_buf_d;
  logic [31:0]           mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [IF_BYTES*8-1:0] if_data_q, if_data_d;
  logic [31:0]           lsb_r_data_q, lsb_r_data_d;
  logic                  stall;

  assign cnt_inc = cnt_q + 1'b1;
  assign stall   = (state_q == LS_WRITE) && io_buffer_full && (base_q[17:16] == IO_SEG);

  // Write strobe is gated combinationally so a stall or rdy drop suppresses
  // the write in the very cycle it occurs.
  assign mem_wr     = mem_wr_q & rdy & ~stall;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign lsb_done   = lsb_done_q;
  assign lsb_r_data = lsb_r_data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    ld_buf_d     = ld_buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = if_done_q;
    lsb_done_d   = lsb_done_q;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;
    if (rdy) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!if_done_q && !lsb_done_q && !rob_clear) begin
            if (lsb_en) begin
              base_d  = lsb_addr;
              len_d   = lsb_len;
              wdata_d = lsb_w_data;
              cnt_d   = '0;
              mem_a_d = lsb_addr;
              if (lsb_wr) begin
                state_d    = LS_WRITE;
                mem_wr_d   = 1'b1;
                mem_dout_d = lsb_w_data[7:0];
              end else begin
                state_d  = LS_READ;
                ld_buf_d = '0;
              end
            end else if (if_en) begin
              state_d = IF_READ;
              base_d  = if_pc;
              cnt_d   = '0;
              mem_a_d = if_pc;
            end
          end
        end
        IF_READ: begin
          if (rob_clear) begin
            state_d = IDLE;
          end else begin
            // Byte k-1 arrives one cycle after its address, i.e. when cnt == k.
            for (int unsigned i = 0; i < IF_BYTES; i++)
              if (32'(cnt_q) == i + 1) if_data_d[8*i +: 8] = mem_din;
            if (32'(cnt_q) == IF_BYTES) begin
              state_d   = IDLE;
              if_done_d = 1'b1;
            end else begin
              cnt_d   = cnt_inc;
              mem_a_d = base_q + 32'(cnt_inc);
            end
          end
        end
        LS_READ: begin
          if (rob_clear) begin
            state_d = IDLE;
          end else begin
            for (int unsigned i = 0; i < 4; i++)
              if (32'(cnt_q) == i + 1) ld_buf_d[8*i +: 8] = mem_din;
            if (cnt_q == {4'd0, len_q}) begin
              state_d      = IDLE;
              lsb_done_d   = 1'b1;
              lsb_r_data_d = ld_buf_d;
            end else begin
              cnt_d   = cnt_inc;
              mem_a_d = base_q + 32'(cnt_inc);
            end
          end
        end
        LS_WRITE: begin
          if (!stall) begin
            if (cnt_inc == {4'd0, len_q}) begin
              state_d    = IDLE;
              mem_wr_d   = 1'b0;
              lsb_done_d = 1'b1;
            end else begin
              cnt_d      = cnt_inc;
              mem_a_d    = base_q + 32'(cnt_inc);
              mem_dout_d = byte_sel(wdata_q, cnt_inc[1:0]);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      ld_buf_q     <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      ld_buf_q     <= ld_buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, arbitration, stores, IO stall, flush,
// rdy freeze and asynchronous reset, against a byte-wide RAM model.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy = 1'b0;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full = 1'b0;
  logic         if_en = 1'b0;
  logic [31:0]  if_pc = '0;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en = 1'b0;
  logic         lsb_wr = 1'b0;
  logic [31:0]  lsb_addr = '0;
  logic [2:0]   lsb_len = '0;
  logic [31:0]  lsb_w_data = '0;
  logic         lsb_done;
  logic [31:0]  lsb_r_data;
  logic         rob_clear = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int if_done_cnt  = 0;
  int lsb_done_cnt = 0;
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [7:0]  ram [4096];

  always #5 clk = ~clk;

  mem_ctrl #(.IF_BYTES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .rob_clear(rob_clear)
  );

  // RAM returns the byte for the address seen at this edge during the next cycle.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
    if (if_done) if_done_cnt++;
    if (lsb_done) lsb_done_cnt++;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of negedges until the pulse is seen, or -1 on timeout.
  task automatic wait_for(input bit want_if, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = want_if ? if_done : lsb_done;
    end
    if (!seen) n = -1;
  endtask

  initial begin
    logic [511:0] exp_blk;
    int n;
    int c;

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
    for (int k = 0; k < 64; k++) ram[256 + k] = 8'(k);
    ram[32] = 8'hEF; ram[33] = 8'hBE; ram[34] = 8'hAD; ram[35] = 8'hDE;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_lsb_done", lsb_done, 1'b0);
    check("rst_if_data", if_data, 512'h0);
    check("rst_lsb_r_data", lsb_r_data, 32'h0);
    rst = 1'b1;
    rdy = 1'b1;
    @(negedge clk);

    // block fetch from 0x100: done in cycle 66
    if_en = 1'b1; if_pc = 32'h100;
    @(negedge clk);
    check("fetch_addr_k0", mem_a, 32'h100);
    repeat (10) @(negedge clk);
    check("fetch_addr_k10", mem_a, 32'h10A);
    wait_for(1'b1, 200, n);
    check("fetch_latency", n, 55);
    if_en = 1'b0;
    for (int k = 0; k < 64; k++) exp_blk[8*k +: 8] = 8'(k);
    check("fetch_data", if_data, exp_blk);
    @(negedge clk);
    check("fetch_done_pulse", if_done, 1'b0);

    // simultaneous load and fetch: load first
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h20; lsb_len = 3'd4;
    if_en = 1'b1; if_pc = 32'h140;
    @(negedge clk);
    check("arb_load_first", mem_a, 32'h20);
    check("arb_rdata_pre", lsb_r_data, 32'h0);
    wait_for(1'b0, 20, n);
    check("arb_load_latency", n, 5);
    check("arb_load_data", lsb_r_data, 32'hDEADBEEF);
    check("arb_no_fetch_yet", if_done_cnt, 1);
    lsb_en = 1'b0;
    repeat (2) @(negedge clk);
    check("arb_fetch_start", mem_a, 32'h140);
    wait_for(1'b1, 200, n);
    check("arb_fetch_latency", n, 65);
    if_en = 1'b0;
    for (int k = 0; k < 64; k++) exp_blk[8*k +: 8] = ram[320 + k];
    check("arb_fetch_data", if_data, exp_blk);
    check("arb_rdata_stable", lsb_r_data, 32'hDEADBEEF);

    // 2-byte store
    @(negedge clk);
    wlog_a.delete(); wlog_d.delete();
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30; lsb_len = 3'd2; lsb_w_data = 32'h0000ABCD;
    @(negedge clk);
    check("st2_wr_c1", mem_wr, 1'b1);
    wait_for(1'b0, 20, n);
    check("st2_latency", n, 2);
    check("st2_wr_low_at_done", mem_wr, 1'b0);
    lsb_en = 1'b0;
    check("st2_count", wlog_a.size(), 2);
    check("st2_a0", wlog_a[0], 32'h30);
    check("st2_d0", wlog_d[0], 8'hCD);
    check("st2_a1", wlog_a[1], 32'h31);
    check("st2_d1", wlog_d[1], 8'hAB);

    // IO store stalled by a full UART buffer
    @(negedge clk);
    wlog_a.delete(); wlog_d.delete();
    io_buffer_full = 1'b1;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd1; lsb_w_data = 32'h5A;
    repeat (4) @(negedge clk);
    check("io_stall_wr", mem_wr, 1'b0);
    check("io_stall_count", wlog_a.size(), 0);
    io_buffer_full = 1'b0;
    #1;
    check("io_release_wr", mem_wr, 1'b1);
    wait_for(1'b0, 20, n);
    check("io_latency", n, 1);
    lsb_en = 1'b0;
    check("io_count", wlog_a.size(), 1);
    check("io_a", wlog_a[0], 32'h30000);
    check("io_d", wlog_d[0], 8'h5A);

    // flush during fetch byte 10, then flush held one cycle in IDLE
    @(negedge clk);
    c = if_done_cnt;
    if_en = 1'b1; if_pc = 32'h100;
    repeat (11) @(negedge clk);
    rob_clear = 1'b1; if_en = 1'b0;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h22; lsb_len = 3'd1;
    repeat (2) @(negedge clk);
    rob_clear = 1'b0;
    wait_for(1'b0, 20, n);
    check("flush_load_latency", n, 3);
    check("flush_load_zext", lsb_r_data, 32'h000000AD);
    lsb_en = 1'b0;
    repeat (70) @(negedge clk);
    check("flush_no_if_done", if_done_cnt, c);

    // store runs through a flush; non-IO address ignores buffer-full
    wlog_a.delete(); wlog_d.delete();
    io_buffer_full = 1'b1;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h40; lsb_len = 3'd4; lsb_w_data = 32'h11223344;
    repeat (2) @(negedge clk);
    rob_clear = 1'b1;
    @(negedge clk);
    rob_clear = 1'b0;
    wait_for(1'b0, 20, n);
    check("st4_latency", n, 2);
    lsb_en = 1'b0; io_buffer_full = 1'b0;
    check("st4_count", wlog_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("st4_a%0d", k), wlog_a[k], 32'h40 + 32'(k));
      check($sformatf("st4_d%0d", k), wlog_d[k], lsb_w_data[8*k +: 8]);
    end

    // rdy low freezes a store and masks mem_wr
    @(negedge clk);
    wlog_a.delete(); wlog_d.delete();
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h50; lsb_len = 3'd1; lsb_w_data = 32'h77;
    @(negedge clk);
    rdy = 1'b0;
    #1;
    check("rdy_wr_masked", mem_wr, 1'b0);
    check("rdy_addr_held", mem_a, 32'h50);
    repeat (2) @(negedge clk);
    check("rdy_no_write", wlog_a.size(), 0);
    check("rdy_no_done", lsb_done, 1'b0);
    rdy = 1'b1;
    wait_for(1'b0, 10, n);
    check("rdy_latency", n, 1);
    lsb_en = 1'b0;
    check("rdy_count", wlog_a.size(), 1);
    check("rdy_d", wlog_d[0], 8'h77);

    // asynchronous reset mid-load
    @(negedge clk);
    c = lsb_done_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h20; lsb_len = 3'd4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_mem_dout", mem_dout, 8'h0);
    check("arst_lsb_r_data", lsb_r_data, 32'h0);
    check("arst_if_data", if_data, 512'h0);
    lsb_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_no_done", lsb_done_cnt, c);
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h22; lsb_len = 3'd2;
    wait_for(1'b0, 20, n);
    check("post_rst_latency", n, 4);
    check("post_rst_data", lsb_r_data, 32'h0000DEAD);
    lsb_en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
